rob_multi_wb: RTL

- Parametrised reorder buffer for the out-of-order core. Successor to the single-result-bus ROB.
- Entries are allocated in program order at decode. Each allocation returns a tag (the entry index). Execution units write results back by tag, not by PC match.
- Retires one ready entry per cycle from the head.
- Supports NUM_WB parallel write-back channels, branch-mispredict tail rollback, precise exception flush, and a full/empty handshake.

---
 rtl/rob_pkg.sv | 24 ++
 rtl/rob_wb_match.sv | 37 +++
 rtl/rob_multi_wb.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// Shared types and constants for the multi-write-back reorder buffer.
// Entry data fields are ROB_XLEN wide; instantiate rob_multi_wb with XLEN equal to ROB_XLEN.
package rob_pkg;

    localparam int ROB_XLEN = 32;
    localparam int DEST_LSB = 7;
    localparam int DEST_MSB = 11;

    function automatic int tag_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef struct packed {
        logic                valid;
        logic                ready;
        logic                exc;
        logic                reg_write;
        logic [ROB_XLEN-1:0] value;
        logic [ROB_XLEN-1:0] addr;
        logic [ROB_XLEN-1:0] inst;
        logic [ROB_XLEN-1:0] pc;
    } rob_entry_t;

endpackage

// File: rtl/rob_wb_match.sv
// Per-entry write-back match across all channels; the highest channel index wins
// value/addr while exception flags from every hitting channel are OR-ed together.
module rob_wb_match
    import rob_pkg::*;
#(
    parameter int NUM_WB = 4,
    parameter int TAG_W  = 4,
    parameter int XLEN   = ROB_XLEN
) (
    input  logic [TAG_W-1:0]       entry_tag,
    input  logic [NUM_WB-1:0]      wb_valid,
    input  logic [NUM_WB*TAG_W-1:0] wb_tag,
    input  logic [NUM_WB*XLEN-1:0] wb_value,
    input  logic [NUM_WB*XLEN-1:0] wb_addr,
    input  logic [NUM_WB-1:0]      wb_exc,
    output logic                   hit,
    output logic [XLEN-1:0]        value,
    output logic [XLEN-1:0]        addr,
    output logic                   exc
);

    always_comb begin
        hit   = 1'b0;
        value = '0;
        addr  = '0;
        exc   = 1'b0;
        for (int k = 0; k < NUM_WB; k++) begin
            if (wb_valid[k] && (wb_tag[k*TAG_W +: TAG_W] == entry_tag)) begin
                hit   = 1'b1;
                value = wb_value[k*XLEN +: XLEN];
                addr  = wb_addr[k*XLEN +: XLEN];
                exc   = exc | wb_exc[k];
            end
        end
    end

endmodule

// File: rtl/rob_multi_wb.sv
// Reorder buffer with NUM_WB tag-addressed write-back channels, in-order single retire,
// branch-mispredict tail rollback and precise exception flush.
module rob_multi_wb
    import rob_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int XLEN   = ROB_XLEN,
    parameter int NUM_WB = 4,
    parameter int TAG_W  = tag_width(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alloc_valid,
    output logic                    alloc_ready,
    input  logic [XLEN-1:0]         alloc_pc,
    input  logic [XLEN-1:0]         alloc_inst,
    input  logic                    alloc_reg_write,
    output logic [TAG_W-1:0]        alloc_tag,
    input  logic [NUM_WB-1:0]       wb_valid,
    input  logic [NUM_WB*TAG_W-1:0] wb_tag,
    input  logic [NUM_WB*XLEN-1:0]  wb_value,
    input  logic [NUM_WB*XLEN-1:0]  wb_addr,
    input  logic [NUM_WB-1:0]       wb_exc,
    input  logic                    br_valid,
    input  logic [TAG_W-1:0]        br_tag,
    input  logic                    br_mispredict,
    input  logic [XLEN-1:0]         br_target,
    output logic                    commit_valid,
    output logic [XLEN-1:0]         commit_value,
    output logic [4:0]              commit_dest,
    output logic                    commit_reg_write,
    output logic [XLEN-1:0]         commit_addr,
    output logic [XLEN-1:0]         commit_pc,
    output logic                    exception_sig,
    output logic                    flush_out,
    output logic [TAG_W:0]          count
);

    localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(DEPTH);
    localparam logic [TAG_W:0] ONE_COUNT  = (TAG_W+1)'(1);

    rob_entry_t       rob_reg [DEPTH];
    rob_entry_t       head_entry;
    logic [TAG_W-1:0] head_reg;
    logic [TAG_W-1:0] tail_reg;
    logic [TAG_W:0]   count_reg;
    logic [TAG_W:0]   count_next;
    logic [TAG_W-1:0] br_age;
    logic             head_fire;
    logic             commit_fire;
    logic             exc_flush;
    logic             mispredict;
    logic             alloc_fire;

    // Retirement decisions look only at registered head state, so a result
    // written back this cycle retires no earlier than next cycle.
    assign head_entry  = rob_reg[head_reg];
    assign head_fire   = head_entry.valid && head_entry.ready;
    assign commit_fire = head_fire && !head_entry.exc;
    assign exc_flush   = head_fire && head_entry.exc;
    assign mispredict  = br_valid && br_mispredict && !exc_flush;
    assign alloc_ready = (count_reg != FULL_COUNT) && !(br_valid && br_mispredict) && !exc_flush;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign br_age      = br_tag - head_reg;

    always_comb begin
        count_next = count_reg;
        if (exc_flush) begin
            count_next = '0;
        end else if (mispredict) begin
            count_next = {1'b0, br_age} + ONE_COUNT - {{TAG_W{1'b0}}, commit_fire};
        end else begin
            count_next = count_reg + {{TAG_W{1'b0}}, alloc_fire} - {{TAG_W{1'b0}}, commit_fire};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || exc_flush) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (commit_fire) begin
                head_reg <= head_reg + 1'b1;
            end
            if (mispredict) begin
                tail_reg <= br_tag + 1'b1;
            end else if (alloc_fire) begin
                tail_reg <= tail_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            localparam logic [TAG_W-1:0] IDX = TAG_W'(gi);

            rob_entry_t       entry_reg;
            logic             wb_hit;
            logic             wb_exc_any;
            logic [XLEN-1:0]  wb_val;
            logic [XLEN-1:0]  wb_adr;
            logic [TAG_W-1:0] age;
            logic             is_younger;

            rob_wb_match #(
                .NUM_WB (NUM_WB),
                .TAG_W  (TAG_W),
                .XLEN   (XLEN)
            ) u_match (
                .entry_tag (IDX),
                .wb_valid  (wb_valid),
                .wb_tag    (wb_tag),
                .wb_value  (wb_value),
                .wb_addr   (wb_addr),
                .wb_exc    (wb_exc),
                .hit       (wb_hit),
                .value     (wb_val),
                .addr      (wb_adr),
                .exc       (wb_exc_any)
            );

            // Age relative to head; anything older-in-index but younger-in-program
            // than the mispredicted branch is squashed, including its same-cycle write-backs.
            assign age        = IDX - head_reg;
            assign is_younger = mispredict && (age > br_age);

            always_ff @(posedge clk) begin
                if (rst || exc_flush || is_younger) begin
                    entry_reg <= '0;
                end else if (alloc_fire && (tail_reg == IDX)) begin
                    entry_reg.valid     <= 1'b1;
                    entry_reg.ready     <= 1'b0;
                    entry_reg.exc       <= 1'b0;
                    entry_reg.reg_write <= alloc_reg_write;
                    entry_reg.value     <= '0;
                    entry_reg.addr      <= '0;
                    entry_reg.inst      <= alloc_inst;
                    entry_reg.pc        <= alloc_pc;
                end else if (entry_reg.valid) begin
                    if (commit_fire && (head_reg == IDX)) begin
                        entry_reg <= '0;
                    end else begin
                        if (wb_hit) begin
                            entry_reg.ready <= 1'b1;
                            entry_reg.value <= wb_val;
                            entry_reg.addr  <= wb_adr;
                            entry_reg.exc   <= entry_reg.exc | wb_exc_any;
                        end
                        if (br_valid && (br_tag == IDX)) begin
                            entry_reg.ready <= 1'b1;
                            entry_reg.value <= br_target;
                        end
                    end
                end
            end

            assign rob_reg[gi] = entry_reg;
        end
    endgenerate

    assign alloc_tag        = tail_reg;
    assign count            = count_reg;
    assign commit_valid     = commit_fire;
    assign commit_value     = commit_fire ? head_entry.value : '0;
    assign commit_addr      = commit_fire ? head_entry.addr : '0;
    assign commit_pc        = commit_fire ? head_entry.pc : '0;
    assign commit_reg_write = commit_fire && head_entry.reg_write;
    assign commit_dest      = commit_fire ? head_entry.inst[DEST_MSB:DEST_LSB] : 5'd0;
    assign exception_sig    = exc_flush;
    assign flush_out        = exc_flush || mispredict;

endmodule
